// File: rtl/multiword_adder_ctrl.sv
// Multi-word adder sequencer: one W = N*WORDS bit addition is done by a single
// N-bit adder, one word per clock, least-significant word first.

module adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] q,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] total_s;

    assign total_s = {1'b0, p} + {1'b0, q} + {{N{1'b0}}, ci};
    assign s       = total_s[N-1:0];
    assign co      = total_s[N];
endmodule

module multiword_adder_ctrl #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-N-1:0]     part_q, part_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [N-1:0]       add_p_s, add_q_s, add_sum_s;
    logic               add_co_s;

    // Select the operand word addressed by idx for the shared adder.
    always_comb begin
        add_p_s = {N{1'b0}};
        add_q_s = {N{1'b0}};
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                add_p_s = a_q[w*N +: N];
                add_q_s = b_q[w*N +: N];
            end else begin
                add_p_s = add_p_s;
                add_q_s = add_q_s;
            end
        end
    end

    adder_n #(.N(N)) u_adder (
        .p  (add_p_s),
        .q  (add_q_s),
        .ci (carry_q),
        .s  (add_sum_s),
        .co (add_co_s)
    );

    // Next-state logic: accept in IDLE/DONE, step one word per cycle in RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                carry_d = add_co_s;
                for (int w = 0; w < WORDS - 1; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        part_d[w*N +: N] = add_sum_s;
                    end else begin
                        part_d[w*N +: N] = part_q[w*N +: N];
                    end
                end
                // The MS word goes straight into sum so partial words never reach the port.
                if (idx_q == LAST_IDX) begin
                    sum_d   = {add_sum_s, part_q};
                    cout_d  = add_co_s;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            part_q  <= {(W-N){1'b0}};
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Directed and random checks for multiword_adder_ctrl with N=4, WORDS=4.

module tb_multiword_adder_ctrl;
    logic        clk;
    logic        n_reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    int errors = 0;
    int checks = 0;

    multiword_adder_ctrl #(.N(4), .WORDS(4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a negedge; holds start for one cycle and returns at the next negedge.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles until done is seen; bounded so a stuck DUT cannot hang.
    task automatic wait_done(output int cyc, output bit got);
        cyc = 0; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_basic();
        int cyc; bit got;
        start_op(16'h1234, 16'h4321, 1'b0);
        a = 16'hAAAA; b = 16'hAAAA; cin = 1'b1;
        wait_done(cyc, got);
        checks++; if (!got) begin errors++; $display("FAIL t1_done_timeout got=0 exp=1"); end
        checks++; if (cyc != 4) begin errors++; $display("FAIL t1_busy_cycles got=%0d exp=4", cyc); end
        checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL t1_sum got=%h exp=5555", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL t1_cout got=%b exp=0", cout); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got=%b exp=0", done); end
        checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL t1_sum_hold got=%h exp=5555", sum); end
    endtask

    task automatic test_carry_chain();
        int cyc; bit got;
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(cyc, got);
        checks++; if (!got) begin errors++; $display("FAIL t2_done_timeout got=0 exp=1"); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL t2_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL t2_cout got=%b exp=1", cout); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; bit got;
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(cyc, got);
        checks++; if (!got) begin errors++; $display("FAIL t3_done_timeout got=0 exp=1"); end
        checks++; if (sum !== 16'hFFFF) begin errors++; $display("FAIL t3_sum got=%h exp=ffff", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL t3_cout got=%b exp=1", cout); end
        start_op(16'h0000, 16'h0000, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t3_b2b_busy got=%b exp=1", busy); end
        wait_done(cyc, got);
        checks++; if (!got || cyc != 4) begin
            errors++; $display("FAIL t3_b2b_timing got=%0d/%0d exp=1/4", got, cyc);
        end
        checks++; if (sum !== 16'h0001) begin errors++; $display("FAIL t3_b2b_sum got=%h exp=0001", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL t3_b2b_cout got=%b exp=0", cout); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int dcount = 0;
        logic [15:0] s = 16'hDEAD;
        logic c = 1'bx;
        start_op(16'h0F0F, 16'h00F1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            if (done) begin dcount++; s = sum; c = cout; end
            if (k == 1) begin a = 16'hFFFF; b = 16'hFFFF; start = 1'b1; end
            else if (k == 2) start = 1'b0;
            @(negedge clk);
        end
        checks++; if (dcount != 1) begin errors++; $display("FAIL t4_done_count got=%0d exp=1", dcount); end
        checks++; if (s !== 16'h1000) begin errors++; $display("FAIL t4_sum got=%h exp=1000", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL t4_cout got=%b exp=0", c); end
    endtask

    task automatic test_reset_mid_run();
        int cyc; bit got;
        start_op(16'h0123, 16'h0456, 1'b0);
        @(negedge clk);
        #1 n_reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t5_done got=%b exp=0", done); end
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL t5_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL t5_cout got=%b exp=0", cout); end
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        start_op(16'h0001, 16'h0001, 1'b0);
        wait_done(cyc, got);
        checks++; if (!got || sum !== 16'h0002 || cout !== 1'b0) begin
            errors++; $display("FAIL t5_after got=%0d %b_%h exp=1 0_0002", got, cout, sum);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc; bit got;
        int rerr = 0;
        logic [15:0] ra, rb;
        logic [16:0] expv;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 500; i++) begin
                ra = 16'($urandom_range(0, 65535));
                rb = 16'($urandom_range(0, 65535));
                expv = {1'b0, ra} + {1'b0, rb} + {16'h0, c[0]};
                start_op(ra, rb, c[0]);
                wait_done(cyc, got);
                checks++;
                if (!got || {cout, sum} !== expv) begin
                    errors++; rerr++;
                    $display("FAIL rand a=%h b=%h cin=%0d got=%b_%h exp=%b_%h",
                             ra, rb, c, cout, sum, expv[16], expv[15:0]);
                end
            end
        end
        if (rerr == 0) $display("random test PASS");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
